vga_fb_reader: RTL and testbench

//  Pixel stage directly downstream of the VGA sync generator. Consumes pixel_x/pixel_y/video_on/hsync/vsync,

---
 rtl/vga_fb_reader.sv | 111 +++++++++++
 tb/tb_vga_fb_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// Pixel stage behind the VGA sync generator: scaled RGB332 framebuffer fetch, 3-clk aligned colour/sync output.
// Optional border ring enabled by defining VGA_BORDER_EN.
module vga_fb_reader #(
    parameter int          SCALE_SHIFT  = 2,
    parameter int          FB_W         = 160,
    parameter int          FB_H         = 120,
    parameter int          ADDR_W       = 15,
    parameter logic [7:0]  BORDER_COLOR = 8'hE0
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync,
    input  logic              vsync,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start,
    output logic [7:0]        frame_count
);

    function automatic logic [11:0] expand332(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    logic [9:0]        fx, fy;
    logic              in_range, first_px;
    logic [ADDR_W-1:0] addr_next;

    assign fx        = pixel_x >> SCALE_SHIFT;
    assign fy        = pixel_y >> SCALE_SHIFT;
    assign in_range  = video_on && (fx < 10'(FB_W)) && (fy < 10'(FB_H));
    assign first_px  = video_on && (pixel_x == 10'd0) && (pixel_y == 10'd0);
    // constant multiplier only; no divider needed anywhere
    assign addr_next = ADDR_W'(fy) * ADDR_W'(FB_W) + ADDR_W'(fx);

    logic s1_in_range, s1_hs, s1_vs, s1_first;
    logic s2_in_range, s2_hs, s2_vs, s2_first;
    logic [11:0] colour;

`ifdef VGA_BORDER_EN
    logic border, s1_border, s2_border;
    assign border = video_on && (pixel_x == 10'd0 || pixel_x == 10'd639 ||
                                 pixel_y == 10'd0 || pixel_y == 10'd479);
`endif

    always_comb begin
        colour = s2_in_range ? expand332(fb_data) : 12'h000;
`ifdef VGA_BORDER_EN
        if (s2_border)
            colour = expand332(BORDER_COLOR);
`endif
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            fb_rd_en    <= 1'b0;
            fb_addr     <= '0;
            s1_in_range <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_first    <= 1'b0;
            s2_in_range <= 1'b0;
            s2_hs       <= 1'b1;
            s2_vs       <= 1'b1;
            s2_first    <= 1'b0;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= 8'h00;
`ifdef VGA_BORDER_EN
            s1_border   <= 1'b0;
            s2_border   <= 1'b0;
`endif
        end else begin
            fb_addr     <= addr_next;
            fb_rd_en    <= in_range;
            s1_in_range <= in_range;
            s1_hs       <= hsync;
            s1_vs       <= vsync;
            s1_first    <= first_px;

            s2_in_range <= s1_in_range;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_first    <= s1_first;

            {vga_r, vga_g, vga_b} <= colour;
            vga_hsync   <= s2_hs;
            vga_vsync   <= s2_vs;
            frame_start <= s2_first;
            if (s2_first)
                frame_count <= frame_count + 8'd1;
`ifdef VGA_BORDER_EN
            s1_border   <= border;
            s2_border   <= s1_border;
`endif
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader with a 1-clk sync-read RAM model; border case runs when VGA_BORDER_EN is defined.
module tb_vga_fb_reader;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync, vsync;
    logic        fb_rd_en;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, frame_start;
    logic [7:0]  frame_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem [0:32767];

    vga_fb_reader dut (
        .clk_25mhz(clk_25mhz), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync(hsync), .vsync(vsync),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz)
        if (fb_rd_en) fb_data <= mem[fb_addr];

    task automatic tick;
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic drive(input logic vo, input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs);
        video_on = vo;
        pixel_x  = x;
        pixel_y  = y;
        hsync    = hs;
        vsync    = vs;
    endtask

    task automatic test_reset;
        drive(1'b1, 10'd0, 10'd0, 1'b1, 1'b1);
        tick;
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick;
        tick;
        n_cmp++;
        if (frame_start !== 1'b1 || frame_count !== 8'd1) begin
            n_fail++;
            $display("FAIL pre_reset_frame: fs=%b fc=%0d, want fs=1 fc=1", frame_start, frame_count);
        end
        drive(1'b1, 10'd8, 10'd4, 1'b0, 1'b0);
        tick; tick; tick;
        reset = 1'b1;
        repeat (5) tick;
        n_cmp++;
        if (fb_rd_en !== 1'b0 || fb_addr !== 15'd0 || {vga_r, vga_g, vga_b} !== 12'h000 ||
            vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || frame_start !== 1'b0 || frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: rd=%b addr=%0d rgb=%h hs=%b vs=%b fs=%b fc=%0d, want 0 0 000 1 1 0 0",
                     fb_rd_en, fb_addr, {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, frame_start, frame_count);
        end
        reset = 1'b0;
        tick;
        n_cmp++;
        if (fb_addr !== 15'd162 || fb_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL release_s1: addr=%0d rd=%b, want 162 1", fb_addr, fb_rd_en);
        end
        tick;
        n_cmp++;
        if (vga_hsync !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL release_2clk: hs=%b rgb=%h, want 1 000", vga_hsync, {vga_r, vga_g, vga_b});
        end
        tick;
        n_cmp++;
        if (vga_hsync !== 1'b0 || vga_vsync !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'hFFF) begin
            n_fail++;
            $display("FAIL release_3clk: hs=%b vs=%b rgb=%h, want 0 0 fff", vga_hsync, vga_vsync, {vga_r, vga_g, vga_b});
        end
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick; tick; tick;
    endtask

    task automatic test_addr;
        drive(1'b1, 10'd8, 10'd4, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if (fb_addr !== 15'd162 || fb_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_8_4: addr=%0d rd=%b, want 162 1", fb_addr, fb_rd_en);
        end
        drive(1'b1, 10'd639, 10'd479, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if (fb_addr !== 15'd19199 || fb_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_last: addr=%0d rd=%b, want 19199 1", fb_addr, fb_rd_en);
        end
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL rgb_not_yet: rgb=%h, want 000", {vga_r, vga_g, vga_b});
        end
        drive(1'b1, 10'd640, 10'd0, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            n_fail++;
            $display("FAIL rgb_8_4: rgb=%h, want fff", {vga_r, vga_g, vga_b});
        end
        n_cmp++;
        if (fb_addr !== 15'd160 || fb_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL out_of_fb: addr=%0d rd=%b, want 160 0", fb_addr, fb_rd_en);
        end
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'h0F0) begin
            n_fail++;
            $display("FAIL rgb_last: rgb=%h, want 0f0", {vga_r, vga_g, vga_b});
        end
        tick;
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL rgb_out_of_fb: rgb=%h, want 000", {vga_r, vga_g, vga_b});
        end
        tick;
    endtask

    task automatic test_colour;
        drive(1'b1, 10'd12, 10'd8, 1'b1, 1'b1);
        tick;
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if (fb_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_blank: rd=%b, want 0", fb_rd_en);
        end
        tick;
        n_cmp++;
        if (vga_r !== 4'b1011 || vga_g !== 4'b0100 || vga_b !== 4'b0101) begin
            n_fail++;
            $display("FAIL expand_a9: r=%b g=%b b=%b, want 1011 0100 0101", vga_r, vga_g, vga_b);
        end
        tick;
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL rgb_blank: rgb=%h, want 000", {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp_rgb [0:5];
        exp_rgb[0] = 12'hFFF; exp_rgb[1] = 12'h000; exp_rgb[2] = 12'hB45;
        exp_rgb[3] = 12'hF00; exp_rgb[4] = 12'h0F0; exp_rgb[5] = 12'h00F;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive(1'b1, 10'(c * 4), 10'd40, 1'b1, 1'b1);
            else       drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
            tick;
            if (c < 6) begin
                n_cmp++;
                if (fb_addr !== 15'(1600 + c) || fb_rd_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_addr[%0d]: addr=%0d rd=%b, want %0d 1", c, fb_addr, fb_rd_en, 1600 + c);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if ({vga_r, vga_g, vga_b} !== exp_rgb[c-2]) begin
                    n_fail++;
                    $display("FAIL b2b_rgb[%0d]: rgb=%h, want %h", c - 2, {vga_r, vga_g, vga_b}, exp_rgb[c-2]);
                end
            end
        end
        tick;
    endtask

    task automatic test_syncs;
        logic hs, vs, ehs, evs;
        int cyc;
        for (int c = 0; c < 106; c++) begin
            hs = !(c >= 2 && c < 98);
            vs = !(c >= 10 && c < 12);
            drive(1'b0, 10'd0, 10'd0, hs, vs);
            tick;
            cyc = c + 1;
            ehs = !(cyc >= 5 && cyc <= 100);
            evs = !(cyc >= 13 && cyc <= 14);
            n_cmp++;
            if (vga_hsync !== ehs || vga_vsync !== evs) begin
                n_fail++;
                $display("FAIL sync_delay[cyc %0d]: hs=%b vs=%b, want %b %b", cyc, vga_hsync, vga_vsync, ehs, evs);
            end
        end
    endtask

    task automatic test_frames;
        localparam int TOTAL = 256 * 6;
        int  k;
        logic efs;
        logic [7:0] efc;
        reset = 1'b1;
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick;
        reset = 1'b0;
        for (int c = 0; c < TOTAL + 2; c++) begin
            if (c < TOTAL) begin
                case (c % 6)
                    0: drive(1'b1, 10'd0, 10'd0, 1'b1, 1'b1);
                    1: drive(1'b1, 10'd1, 10'd0, 1'b1, 1'b1);
                    2: drive(1'b1, 10'd0, 10'd1, 1'b1, 1'b1);
                    5: drive(1'b1, 10'd8, 10'd4, 1'b1, 1'b1);
                    default: drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
                endcase
            end else begin
                drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
            end
            tick;
            k   = c - 2;
            efs = (k >= 0) && (k % 6 == 0);
            efc = (k >= 0) ? 8'((k / 6 + 1) % 256) : 8'd0;
            n_cmp++;
            if (frame_start !== efs || frame_count !== efc) begin
                n_fail++;
                $display("FAIL frame[in %0d]: fs=%b fc=%0d, want %b %0d", k, frame_start, frame_count, efs, efc);
            end
        end
        tick;
        n_cmp++;
        if (frame_count !== 8'd0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_wrap: fc=%0d fs=%b, want 0 0", frame_count, frame_start);
        end
    endtask

`ifdef VGA_BORDER_EN
    task automatic test_border;
        drive(1'b1, 10'd639, 10'd100, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if (fb_addr !== 15'd4159 || fb_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL border_addr: addr=%0d rd=%b, want 4159 1", fb_addr, fb_rd_en);
        end
        drive(1'b1, 10'd1, 10'd1, 1'b1, 1'b1);
        tick;
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'hF00) begin
            n_fail++;
            $display("FAIL border_rgb: rgb=%h, want f00", {vga_r, vga_g, vga_b});
        end
        tick;
        n_cmp++;
        if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            n_fail++;
            $display("FAIL inner_rgb: rgb=%h, want fff", {vga_r, vga_g, vga_b});
        end
        tick;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[0]     = 8'hFF;
        mem[162]   = 8'hFF;
        mem[323]   = 8'hA9;
        mem[19199] = 8'h1C;
        mem[1600]  = 8'hFF; mem[1601] = 8'h00; mem[1602] = 8'hA9;
        mem[1603]  = 8'hE0; mem[1604] = 8'h1C; mem[1605] = 8'h03;
        mem[4159]  = 8'h1C;

        reset = 1'b1;
        drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
        tick; tick;
        reset = 1'b0;

        test_reset;
        test_addr;
        test_colour;
        test_back_to_back;
        test_syncs;
`ifdef VGA_BORDER_EN
        test_border;
`endif
        test_frames;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
